uio_bus_arbiter: RTL and testbench

- Shares the 8-bit bidirectional uio pad bus of the tt_um_bobidibob top level between NREQ internal requesters.
- Drives uio_out and uio_oe for the current owner, returns uio_in data to readers, and inserts a one-cycle high-Z turnaround on every ownership change.
- Uses round-robin arbitration so that no requester starves.
- Sits between the user-logic blocks and the uio_in/uio_out/uio_oe top-level pins.

---
 rtl/uio_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit uio pad bus, with a one-cycle high-Z turnaround on every grant.
// Optional build macro ARB_HOLD_LIMIT_EN: force-release an owner after MAX_HOLD consecutive OWN cycles.
module uio_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [8*NREQ-1:0] wdata,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rdata,
  output logic [NREQ-1:0]   rd_valid,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: req[i] is a level held until the requester is done; gnt[i] is high
  // only while i owns the pins, and dropping req[i] releases the bus at the next edge.

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;

  logic [1:0]      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic            own_dir;

  logic [IW-1:0]   next_ptr;
  logic [IW-1:0]   arb_base;
  logic [IW-1:0]   winner;
  logic            found;
  logic            release_own;
  logic            hold_expired;
  logic [NREQ-1:0] owner_onehot;
  logic [2*NREQ-1:0] req_rot;

  assign next_ptr     = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  // A releasing owner re-arbitrates from the slot after itself, not from the stale ptr.
  assign arb_base     = (state == ST_OWN) ? next_ptr : ptr;
  assign owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << owner;
  assign req_rot      = {req, req} >> arb_base;

  always_comb begin
    logic [IW:0] sum;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, arb_base} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!found && req_rot[k]) begin
        winner = sum[IW-1:0];
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;

  assign hold_expired = (hold_cnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == ST_TURN) begin
      hold_cnt <= '0;
    end else if (state == ST_OWN && hold_cnt != HW'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  // No hold limit: MAX_HOLD is never negative, so this is constant low.
  assign hold_expired = (MAX_HOLD < 0);
`endif

  assign release_own = (state == ST_OWN) && (!req[owner] || !ena || hold_expired);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= '0;
      ptr     <= '0;
      own_dir <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ena && found) begin
            owner   <= winner;
            own_dir <= dir[winner];
            state   <= ST_TURN;
          end
        end
        ST_TURN: state <= ST_OWN;
        ST_OWN: begin
          if (release_own) begin
            ptr <= next_ptr;
            if (ena && found) begin
              owner   <= winner;
              own_dir <= dir[winner];
              state   <= ST_TURN;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata    <= 8'h00;
      rd_valid <= '0;
    end else if (state == ST_OWN && !own_dir) begin
      rdata    <= uio_in;
      rd_valid <= owner_onehot;
    end else begin
      rd_valid <= '0;
    end
  end

  always_comb begin
    gnt     = '0;
    uio_oe  = 8'h00;
    uio_out = 8'h00;
    if (state == ST_OWN) begin
      gnt = owner_onehot;
      if (own_dir) begin
        uio_oe  = 8'hFF;
        uio_out = wdata[{owner, 3'b000} +: 8];
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed test-plan steps followed by randomized traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_uio_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   dir;
  logic [8*NREQ-1:0] wdata;
  logic [7:0]        uio_in;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        rdata;
  logic [NREQ-1:0]   rd_valid;
  logic              busy;
  logic [1:0]        state_dbg;

  uio_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .gnt(gnt), .rdata(rdata),
    .rd_valid(rd_valid), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: who holds the bus, whether its turnaround is still ahead
  int              m_owner = -1;
  bit              m_turn  = 1'b0;
  bit              m_dir   = 1'b0;
  int              m_ptr   = 0;
  int              m_hold  = 0;
  logic [NREQ-1:0] m_rdv   = '0;
  logic [7:0]      exp_rdata = 8'h00;
  logic [7:0]      exp_q[$];

  function automatic int pick(input int base);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (base + k) % NREQ;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    bit owning;
    bit rel;
    int w;
    if (!rst_n) begin
      m_owner = -1; m_turn = 1'b0; m_dir = 1'b0; m_ptr = 0; m_hold = 0;
      m_rdv = '0; exp_rdata = 8'h00; exp_q.delete();
      return;
    end
    owning = (m_owner >= 0) && !m_turn;
    if (owning && !m_dir) begin
      exp_q.push_back(uio_in);
      m_rdv = '0;
      m_rdv[m_owner] = 1'b1;
    end else begin
      m_rdv = '0;
    end
    if (m_turn) begin
      m_turn = 1'b0;
      m_hold = 0;
    end else if (owning) begin
      m_hold++;
      rel = !req[m_owner] || !ena || (HOLD_EN && m_hold >= MAX_HOLD);
      if (rel) begin
        m_ptr = (m_owner + 1) % NREQ;
        w = ena ? pick(m_ptr) : -1;
        if (w >= 0) begin
          m_owner = w; m_dir = dir[w]; m_turn = 1'b1;
        end else begin
          m_owner = -1;
        end
      end
    end else if (ena) begin
      w = pick(m_ptr);
      if (w >= 0) begin
        m_owner = w; m_dir = dir[w]; m_turn = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare every output against the model
  task automatic check_all(input string tag);
    bit owning;
    logic [NREQ-1:0] e_gnt;
    logic [7:0] e_oe, e_out;
    owning = (m_owner >= 0) && !m_turn;
    e_gnt = '0;
    e_oe  = 8'h00;
    e_out = 8'h00;
    if (owning) begin
      e_gnt[m_owner] = 1'b1;
      if (m_dir) begin
        e_oe  = 8'hFF;
        e_out = wdata[m_owner*8 +: 8];
      end
    end
    if (m_rdv != '0 && exp_q.size() > 0) exp_rdata = exp_q.pop_front();
    chk({tag, ".gnt"},      gnt,      e_gnt);
    chk({tag, ".uio_oe"},   uio_oe,   e_oe);
    chk({tag, ".uio_out"},  uio_out,  e_out);
    chk({tag, ".busy"},     busy,     m_owner >= 0);
    chk({tag, ".rd_valid"}, rd_valid, m_rdv);
    chk({tag, ".rdata"},    rdata,    exp_rdata);
  endtask

  // driver tasks
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick("rst");
    tick("rst");
    rst_n = 1'b1;
  endtask

  int order_q[$];
  logic [NREQ-1:0] last_gnt;
  int own_cnt;

  initial begin
    rst_n = 1'b0; ena = 1'b0; req = '0; dir = '0; wdata = '0; uio_in = 8'h00;
    reset_dut();
    chk("reset.gnt", gnt, 0);
    chk("reset.oe", uio_oe, 8'h00);
    chk("reset.busy", busy, 0);

    // single writer: TURN then OWN two cycles after req
    ena = 1'b1; req = 4'b0010; dir = 4'b0010; wdata = 32'h0000_A500;
    tick("w1");
    chk("w1.turn_oe", uio_oe, 8'h00);
    chk("w1.turn_busy", busy, 1);
    tick("w1");
    chk("w1.gnt", gnt, 4'b0010);
    chk("w1.oe", uio_oe, 8'hFF);
    chk("w1.out", uio_out, 8'hA5);
    req = '0;
    tick("w1"); tick("w1");

    // single reader for three OWN cycles
    req = 4'b0001; dir = 4'b0000; uio_in = 8'h3C;
    for (int i = 0; i < 4; i++) tick("r0");
    req = '0;
    tick("r0");
    chk("r0.rd_valid", rd_valid, 4'b0001);
    chk("r0.rdata", rdata, 8'h3C);
    tick("r0"); tick("r0");

    // round robin from ptr=0, each owner keeps the bus for two cycles
    reset_dut();
    req = 4'b1111; dir = 4'($urandom); last_gnt = '0; own_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      wdata = $urandom; uio_in = 8'($urandom);
      tick("rr");
      if (gnt !== '0 && gnt !== last_gnt) order_q.push_back(onehot_idx(gnt));
      last_gnt = gnt;
      if (m_owner >= 0 && !m_turn) begin
        own_cnt++;
        if (own_cnt == 2) begin
          req[m_owner] = 1'b0;
          own_cnt = 0;
        end
      end
    end
    chk("rr.count", order_q.size(), 4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) chk("rr.order", order_q[i], i);

    // ena dropped while owner 2 writes 8'hFF
    req = 4'b0100; dir = 4'b0100; wdata = 32'h00FF_0000;
    tick("ena"); tick("ena");
    chk("ena.own_out", uio_out, 8'hFF);
    ena = 1'b0;
    tick("ena");
    chk("ena.rel_gnt", gnt, 0);
    chk("ena.rel_oe", uio_oe, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick("ena");
      chk("ena.idle_busy", busy, 0);
    end
    ena = 1'b1;
    tick("ena");
    tick("ena");
    chk("ena.regrant", gnt, 4'b0100);

    // reset mid-OWN with req 1 and 3 pending: ptr back to 0, so 1 wins
    req = 4'b1110;
    tick("rmo");
    rst_n = 1'b0;
    tick("rmo");
    chk("rmo.gnt", gnt, 0);
    chk("rmo.oe", uio_oe, 8'h00);
    chk("rmo.out", uio_out, 8'h00);
    chk("rmo.rdata", rdata, 8'h00);
    rst_n = 1'b1;
    tick("rmo"); tick("rmo");
    chk("rmo.winner", gnt, 4'b0010);
    req = '0;
    tick("rmo"); tick("rmo");

    // two requesters held continuously
    reset_dut();
    req = 4'b0011; dir = 4'b0000;
    for (int c = 1; c <= 12; c++) begin
      uio_in = 8'($urandom);
      tick("hold");
`ifdef ARB_HOLD_LIMIT_EN
      if (c == 5) chk("hold.owner0", gnt, 4'b0001);
      if (c == 6) chk("hold.turn", gnt, 0);
      if (c == 7) chk("hold.owner1", gnt, 4'b0010);
`else
      if (c >= 2) chk("hold.keep0", gnt, 4'b0001);
`endif
    end
    req = '0;
    tick("hold"); tick("hold");

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ 4'($urandom);
      dir    = 4'($urandom);
      wdata  = $urandom;
      uio_in = 8'($urandom);
      ena    = ($urandom_range(0, 19) != 0);
      rst_n  = ($urandom_range(0, 149) != 0);
      tick("rand");
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
